// File: rtl/mem_pkg.sv
// mem_pkg: shared sizing, store-type encoding and halfword lane constants for the data memory
package mem_pkg;
  localparam int DEPTH = 1024;
  localparam int IDX_W = 10;
  typedef enum logic [1:0] {ST_NONE, ST_W, ST_H, ST_B} st_t;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
endpackage

// File: rtl/store_align.sv
// store_align: resolves store priority and maps a store onto byte-lane enables and replicated lane data
module store_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic        sw,
  input  logic        sh,
  input  logic        sb,
  output logic [3:0]  be,
  output logic [31:0] lane,
  output logic        align_err
);
  st_t st;
  logic [3:0] be_raw;
  always_comb begin
    st = sw ? ST_W : sh ? ST_H : sb ? ST_B : ST_NONE;
    align_err = (st == ST_W && addr_lo != 2'b00) || (st == ST_H && addr_lo[0]);
    be_raw = st == ST_W ? 4'b1111 :
             st == ST_H ? (addr_lo[1] ? BE_HHI : BE_HLO) :
             st == ST_B ? 4'b0001 << addr_lo : 4'b0000;
    be = align_err ? 4'b0000 : be_raw;
    lane = st == ST_H ? {2{wd[15:0]}} : st == ST_B ? {4{wd[7:0]}} : wd;
  end
endmodule

// File: rtl/data_mem.sv
// data_mem: word-organised MEM-stage data memory with byte-lane stores and a combinational read port
module data_mem #(
  parameter int DEPTH = mem_pkg::DEPTH,
  parameter int IDX_W = mem_pkg::IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        sw,
  input  logic        sh,
  input  logic        sb,
  output logic [31:0] rd,
  output logic [3:0]  be,
  output logic        align_err
);
  logic [31:0] mem [DEPTH] = '{default: '0};
  logic [IDX_W-1:0] idx;
  logic [31:0] lane;
  logic unused_hi;
  assign idx = addr[IDX_W+1:2];
  assign unused_hi = ^addr[31:IDX_W+2];
  store_align u_align (
    .addr_lo(addr[1:0]),
    .wd(wd),
    .sw(sw),
    .sh(sh),
    .sb(sb),
    .be(be),
    .lane(lane),
    .align_err(align_err)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) if (be[i]) mem[idx][8*i +: 8] <= lane[8*i +: 8];
    end
  end
  assign rd = mem[idx];
endmodule
